// File: rtl/svi_field_bank.sv
// Multi-channel bank of x/y/z field bundles with per-channel tick-driven update modes.
// Fields and modes are loaded through a valid/ready write port; a mode write costs one ready bubble.
module svi_field_bank #(
    parameter int W   = 8,
    parameter int NCH = 4,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [CW-1:0]     i_wr_ch,
    input  logic [1:0]        i_wr_sel,
    input  logic [W-1:0]      i_wr_data,
    input  logic              i_tick,
    output logic [NCH*W-1:0]  o_x,
    output logic [NCH*W-1:0]  o_y,
    output logic [NCH*W-1:0]  o_z,
    output logic [NCH*2-1:0]  o_mode,
    output logic              o_err
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_INVERT = 2'd3
    } mode_e;

    localparam logic [1:0] SEL_X    = 2'd0;
    localparam logic [1:0] SEL_Y    = 2'd1;
    localparam logic [1:0] SEL_Z    = 2'd2;
    localparam logic [1:0] SEL_MODE = 2'd3;

    logic [W-1:0] x_q [NCH];
    logic [W-1:0] y_q [NCH];
    logic [W-1:0] z_q [NCH];
    mode_e        mode_q [NCH];
    logic [W-1:0] x_d [NCH];
    logic [W-1:0] y_d [NCH];
    logic [W-1:0] z_d [NCH];
    mode_e        mode_d [NCH];
    logic         err_q, err_d;
    logic         ready_q, ready_d;
    logic         wr_fire_s;
    logic         in_range_s;

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
        return {v[W-2:0], v[W-1]};
    endfunction

    // Next-state: a write to a channel pre-empts that channel's tick step for the cycle.
    always_comb begin
        wr_fire_s  = i_wr_valid && ready_q;
        in_range_s = (int'(i_wr_ch) < NCH);
        err_d      = err_q | (wr_fire_s && !in_range_s);
        ready_d    = !(wr_fire_s && (i_wr_sel == SEL_MODE));
        for (int k = 0; k < NCH; k++) begin
            x_d[k]    = x_q[k];
            y_d[k]    = y_q[k];
            z_d[k]    = z_q[k];
            mode_d[k] = mode_q[k];
            if (wr_fire_s && in_range_s && (int'(i_wr_ch) == k)) begin
                case (i_wr_sel)
                    SEL_X:    x_d[k]    = i_wr_data;
                    SEL_Y:    y_d[k]    = i_wr_data;
                    SEL_Z:    z_d[k]    = i_wr_data;
                    SEL_MODE: mode_d[k] = mode_e'(i_wr_data[1:0]);
                    default:  x_d[k]    = x_q[k];
                endcase
            end else if (i_tick) begin
                case (mode_q[k])
                    MODE_HOLD: x_d[k] = x_q[k];
                    MODE_COUNT: begin
                        x_d[k] = x_q[k] + W'(1);
                        if (&x_q[k]) begin
                            y_d[k] = y_q[k] + W'(1);
                        end else begin
                            y_d[k] = y_q[k];
                        end
                    end
                    MODE_ROTATE: begin
                        x_d[k] = rotl1(x_q[k]);
                        y_d[k] = rotl1(y_q[k]);
                        z_d[k] = rotl1(z_q[k]);
                    end
                    MODE_INVERT: begin
                        x_d[k] = ~x_q[k];
                        y_d[k] = ~y_q[k];
                        z_d[k] = ~z_q[k];
                    end
                    default: x_d[k] = x_q[k];
                endcase
            end else begin
                x_d[k] = x_q[k];
            end
        end
    end

    // State register; reset leaves ready low until the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                x_q[k]    <= '1;
                y_q[k]    <= '0;
                z_q[k]    <= '1;
                mode_q[k] <= MODE_HOLD;
            end
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                x_q[k]    <= x_d[k];
                y_q[k]    <= y_d[k];
                z_q[k]    <= z_d[k];
                mode_q[k] <= mode_d[k];
            end
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_flat
        assign o_x[g*W +: W]  = x_q[g];
        assign o_y[g*W +: W]  = y_q[g];
        assign o_z[g*W +: W]  = z_q[g];
        assign o_mode[2*g +: 2] = mode_q[g];
    end

    assign o_err      = err_q;
    assign o_wr_ready = ready_q;

endmodule

// File: tb/tb_svi_field_bank.sv
// Directed self-checking bench for svi_field_bank (W=8 with NCH=4, plus an NCH=5 instance for range errors).
module tb_svi_field_bank;

    logic        clk;
    logic        rst_n;
    logic        wv, tick;
    logic [1:0]  wch;
    logic [1:0]  wsel;
    logic [7:0]  wdata;
    logic        ready, err;
    logic [31:0] ox, oy, oz;
    logic [7:0]  omode;

    logic        wv5;
    logic [2:0]  wch5;
    logic [1:0]  wsel5;
    logic [7:0]  wdata5;
    logic        ready5, err5;
    logic [39:0] ox5, oy5, oz5;
    logic [9:0]  omode5;

    int passed = 0;
    int total  = 0;

    svi_field_bank #(.W(8), .NCH(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wv), .o_wr_ready(ready),
        .i_wr_ch(wch), .i_wr_sel(wsel), .i_wr_data(wdata), .i_tick(tick),
        .o_x(ox), .o_y(oy), .o_z(oz), .o_mode(omode), .o_err(err)
    );

    svi_field_bank #(.W(8), .NCH(5)) u_dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wv5), .o_wr_ready(ready5),
        .i_wr_ch(wch5), .i_wr_sel(wsel5), .i_wr_data(wdata5), .i_tick(1'b0),
        .o_x(ox5), .o_y(oy5), .o_z(oz5), .o_mode(omode5), .o_err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wv = 1'b0; tick = 1'b0; wch = 2'd0; wsel = 2'd0; wdata = 8'h00;
        wv5 = 1'b0; wch5 = 3'd0; wsel5 = 2'd0; wdata5 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", ox, 32'hFFFF_FFFF);
        chk("reset_y", oy, 32'h0000_0000);
        chk("reset_z", oz, 32'hFFFF_FFFF);
        chk("reset_mode", omode, 8'h00);
        chk("reset_ready", ready, 1'b0);
        chk("reset_err", err, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("ready_rise", ready, 1'b1);
        chk("idle_x", ox, 32'hFFFF_FFFF);

        // COUNT on ch2, with a write presented during the mode bubble
        wv = 1'b1; wch = 2'd2; wsel = 2'd0; wdata = 8'hFE;
        cyc();
        chk("wr_x_ch2", ox[23:16], 8'hFE);
        chk("ready_after_field", ready, 1'b1);
        wsel = 2'd3; wdata = 8'h01;
        cyc();
        chk("mode_ch2", omode[5:4], 2'd1);
        chk("ready_bubble", ready, 1'b0);
        wch = 2'd3; wsel = 2'd0; wdata = 8'h11; tick = 1'b1;
        cyc();
        chk("cnt1_x", ox[23:16], 8'hFF);
        chk("cnt1_y", oy[23:16], 8'h00);
        chk("bubble_reject", ox[31:24], 8'hFF);
        chk("ready_back", ready, 1'b1);
        wv = 1'b0;
        cyc();
        chk("cnt2_x", ox[23:16], 8'h00);
        chk("cnt2_y", oy[23:16], 8'h01);
        cyc();
        chk("cnt3_x", ox, 32'hFF01_FFFF);
        chk("cnt3_y", oy, 32'h0001_0000);
        chk("cnt3_z", oz, 32'hFFFF_FFFF);
        tick = 1'b0;

        // ROTATE on ch1
        wv = 1'b1; wch = 2'd1; wsel = 2'd0; wdata = 8'h81;
        cyc();
        wsel = 2'd1; wdata = 8'h01;
        cyc();
        wsel = 2'd2; wdata = 8'h80;
        cyc();
        wsel = 2'd3; wdata = 8'h02;
        cyc();
        chk("rot_bubble", ready, 1'b0);
        wv = 1'b0; tick = 1'b1;
        cyc();
        chk("rot_x", ox[15:8], 8'h03);
        chk("rot_y", oy[15:8], 8'h02);
        chk("rot_z", oz[15:8], 8'h01);
        chk("rot_cnt_ch2", ox[23:16], 8'h02);
        tick = 1'b0;

        // INVERT on ch0, write and tick collide in one cycle
        wv = 1'b1; wch = 2'd0; wsel = 2'd3; wdata = 8'h03;
        cyc();
        chk("all_modes", omode, 8'h1B);
        chk("inv_bubble", ready, 1'b0);
        wv = 1'b0;
        cyc();
        wv = 1'b1; wsel = 2'd1; wdata = 8'h5A; tick = 1'b1;
        cyc();
        chk("coll_x", ox[7:0], 8'hFF);
        chk("coll_y", oy[7:0], 8'h5A);
        chk("coll_z", oz[7:0], 8'hFF);
        chk("coll_rot_ch1", ox[15:8], 8'h06);
        chk("coll_cnt_ch2", ox[23:16], 8'h03);
        wv = 1'b0;
        cyc();
        chk("inv_x", ox[7:0], 8'h00);
        chk("inv_y", oy[7:0], 8'hA5);
        chk("inv_z", oz[7:0], 8'h00);
        chk("inv_rot_ch1", ox[15:8], 8'h0C);
        chk("inv_cnt_ch2", ox[23:16], 8'h04);
        tick = 1'b0;

        // back-to-back field writes on ch3
        wv = 1'b1; wch = 2'd3; wsel = 2'd0; wdata = 8'h11;
        cyc();
        chk("b2b_x", ox[31:24], 8'h11);
        chk("b2b_ready_x", ready, 1'b1);
        wsel = 2'd1; wdata = 8'h22;
        cyc();
        chk("b2b_y", oy[31:24], 8'h22);
        chk("b2b_ready_y", ready, 1'b1);
        wsel = 2'd2; wdata = 8'h33;
        cyc();
        chk("b2b_z", oz[31:24], 8'h33);
        chk("b2b_ready_z", ready, 1'b1);
        wv = 1'b0;

        // range handling on the 5-channel instance
        wv5 = 1'b1; wch5 = 3'd4; wsel5 = 2'd0; wdata5 = 8'h44;
        cyc();
        chk("ch4_in_range_x", ox5, 40'h44_FFFF_FFFF);
        chk("ch4_no_err", err5, 1'b0);
        wch5 = 3'd5; wdata5 = 8'h55;
        cyc();
        chk("oor_err", err5, 1'b1);
        chk("oor_x_unchanged", ox5, 40'h44_FFFF_FFFF);
        chk("oor_y_unchanged", oy5, 40'h00_0000_0000);
        wv5 = 1'b0;
        cyc();
        chk("err_sticky", err5, 1'b1);
        chk("main_err_clear", err, 1'b0);

        // asynchronous reset away from the clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_err", err5, 1'b0);
        chk("async_x5", ox5, 40'hFF_FFFF_FFFF);
        chk("async_x", ox, 32'hFFFF_FFFF);
        chk("async_y", oy, 32'h0000_0000);
        chk("async_z", oz, 32'hFFFF_FFFF);
        chk("async_mode", omode, 8'h00);
        chk("async_ready", ready, 1'b0);

        // writes during reset are dropped; first accept lands on the second edge after release
        wv = 1'b1; wch = 2'd0; wsel = 2'd0; wdata = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_dropped", ox, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        cyc();
        chk("rel_ready", ready, 1'b1);
        chk("rel_first_edge_no_wr", ox[7:0], 8'hFF);
        cyc();
        chk("rel_second_edge_wr", ox[7:0], 8'h77);
        wv = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
